// File: rtl/serial_frame_receiver.sv
// UART 8N1 receiver that rebuilds 6-byte tracker frames into {decoded_data, timestamp_last_data}.
// One-cycle data_valid on a good frame; one-cycle frame_error on any dropped byte or frame.
module serial_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic        clk_12MHz,
  input  logic        reset_n,
  input  logic        rx,
  output logic        data_valid,
  output logic [16:0] decoded_data,
  output logic [23:0] timestamp_last_data,
  output logic        frame_error
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PAY_W = 42;
  localparam int unsigned DD_W  = 17;
  localparam int unsigned TS_W  = 24;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             r_rx_meta, r_rx_sync;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_bit_idx, w_bit_idx;
  logic [7:0]       r_shift, w_shift;
  logic             r_stop_bad, w_stop_bad;
  logic [2:0]       r_idx, w_idx;
  logic [PAY_W-1:0] r_pay, w_pay;
  logic [DD_W-1:0]  r_dd, w_dd;
  logic [TS_W-1:0]  r_ts, w_ts;
  logic             r_dv, w_dv;
  logic             r_fe, w_fe;
  logic             w_byte_ok;

  assign data_valid          = r_dv;
  assign frame_error         = r_fe;
  assign decoded_data        = r_dd;
  assign timestamp_last_data = r_ts;

  // rx is asynchronous; the second stage idles high so reset never looks like a start bit
  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_bad <= 1'b0;
      r_idx      <= '0;
      r_pay      <= '0;
      r_dd       <= '0;
      r_ts       <= '0;
      r_dv       <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bit_idx  <= w_bit_idx;
      r_shift    <= w_shift;
      r_stop_bad <= w_stop_bad;
      r_idx      <= w_idx;
      r_pay      <= w_pay;
      r_dd       <= w_dd;
      r_ts       <= w_ts;
      r_dv       <= w_dv;
      r_fe       <= w_fe;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit_idx  = r_bit_idx;
    w_shift    = r_shift;
    w_stop_bad = r_stop_bad;
    w_idx      = r_idx;
    w_pay      = r_pay;
    w_dd       = r_dd;
    w_ts       = r_ts;
    w_dv       = 1'b0;
    w_fe       = 1'b0;
    w_byte_ok  = 1'b0;

    // Bit-level deserialiser
    case (r_state)
      IDLE: begin
        if (!r_rx_sync) begin
          w_state   = START;
          w_cnt     = '0;
          w_bit_idx = '0;
        end
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt   = '0;
          w_state = r_rx_sync ? IDLE : DATA;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt     = '0;
          w_shift   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state = STOP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // After a bad stop bit, hold off until the line returns high
        if (r_stop_bad) begin
          if (r_rx_sync) begin
            w_stop_bad = 1'b0;
            w_state    = IDLE;
          end
        end else if (r_cnt == FULL_LAST) begin
          w_cnt = '0;
          if (r_rx_sync) begin
            w_byte_ok = 1'b1;
            w_state   = IDLE;
          end else begin
            w_fe       = 1'b1;
            w_idx      = '0;
            w_stop_bad = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase

    // Frame assembler: bit7 marks byte 0, later bytes carry 7-bit slices MSB first
    if (w_byte_ok) begin
      if (r_shift[7]) begin
        w_pay[41:35] = r_shift[6:0];
        w_idx        = 3'd1;
      end else if (r_idx == 3'd0) begin
        w_fe = 1'b1;
      end else begin
        case (r_idx)
          3'd1:    w_pay[34:28] = r_shift[6:0];
          3'd2:    w_pay[27:21] = r_shift[6:0];
          3'd3:    w_pay[20:14] = r_shift[6:0];
          3'd4:    w_pay[13:7]  = r_shift[6:0];
          3'd5:    w_pay[6:0]   = r_shift[6:0];
          default: ;
        endcase
        if (r_idx == 3'd5) begin
          w_idx = '0;
          if (r_pay[41]) begin
            w_fe = 1'b1;
          end else begin
            w_dv = 1'b1;
            w_dd = r_pay[40:24];
            w_ts = {r_pay[23:7], r_shift[6:0]};
          end
        end else begin
          w_idx = r_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: directed frames plus randomized frames and orphans,
// expected events come from a byte-level frame model and are popped by a pulse monitor.
module tb_serial_frame_receiver;

  localparam int unsigned CPB = 104;

  logic        clk_12MHz;
  logic        reset_n;
  logic        rx;
  logic        data_valid;
  logic [16:0] decoded_data;
  logic [23:0] timestamp_last_data;
  logic        frame_error;

  serial_frame_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk_12MHz          (clk_12MHz),
    .reset_n            (reset_n),
    .rx                 (rx),
    .data_valid         (data_valid),
    .decoded_data       (decoded_data),
    .timestamp_last_data(timestamp_last_data),
    .frame_error        (frame_error)
  );

  initial clk_12MHz = 1'b0;
  always #5 clk_12MHz = ~clk_12MHz;

  typedef struct packed {
    logic        is_err;
    logic [16:0] dd;
    logic [23:0] ts;
  } ev_t;

  ev_t         exp_q[$];
  logic [6:0]  grp_q[$];
  logic [16:0] m_dd;
  logic [23:0] m_ts;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic is_err);
    ev_t e;
    e.is_err = is_err;
    e.dd     = m_dd;
    e.ts     = m_ts;
    exp_q.push_back(e);
  endtask

  // Frame model: collect 7-bit groups; a marker byte restarts, six groups form the payload
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [63:0] acc;
    if (!stop_ok) begin
      grp_q.delete();
      push_ev(1'b1);
    end else if (b[7]) begin
      grp_q.delete();
      grp_q.push_back(b[6:0]);
    end else if (grp_q.size() == 0) begin
      push_ev(1'b1);
    end else begin
      grp_q.push_back(b[6:0]);
      if (grp_q.size() == 6) begin
        acc = 64'd0;
        foreach (grp_q[i]) acc = acc * 64'd128 + 64'(grp_q[i]);
        grp_q.delete();
        if (acc[41]) begin
          push_ev(1'b1);
        end else begin
          m_dd = acc[40:24];
          m_ts = acc[23:0];
          push_ev(1'b0);
        end
      end
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [41:0] p, input int k);
    if (k == 0) return {1'b1, p[41:35]};
    return {1'b0, p[41-7*k -: 7]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int unsigned blen);
    model_byte(b, stop_ok);
    rx = 1'b0;
    repeat (blen) @(negedge clk_12MHz);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (blen) @(negedge clk_12MHz);
    end
    rx = stop_ok;
    repeat (blen) @(negedge clk_12MHz);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (blen) @(negedge clk_12MHz);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [41:0] p);
    for (int k = 0; k < 6; k++) send_byte(frame_byte(p, k), 1'b1, CPB);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 * CPB && exp_q.size() != 0; i++) @(negedge clk_12MHz);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected pulses never seen", name, exp_q.size());
      exp_q.delete();
    end
    repeat (CPB) @(negedge clk_12MHz);
  endtask

  // Monitor: every pulse must match the oldest expected event
  always @(negedge clk_12MHz) begin
    ev_t e;
    if (data_valid || frame_error) begin
      checks++;
      if (data_valid && frame_error) begin
        errors++;
        $display("FAIL both_pulses: data_valid=1 frame_error=1 required never both");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: data_valid=%0d frame_error=%0d required none", data_valid, frame_error);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_err", 64'(frame_error), 64'(e.is_err));
        chk("decoded_data", 64'(decoded_data), 64'(e.dd));
        chk("timestamp", 64'(timestamp_last_data), 64'(e.ts));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] p;
    reset_n = 1'b0;
    rx      = 1'b1;
    m_dd    = '0;
    m_ts    = '0;
    repeat (5) @(negedge clk_12MHz);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_12MHz);
    chk("reset_dv", 64'(data_valid), 64'd0);
    chk("reset_fe", 64'(frame_error), 64'd0);
    chk("reset_dd", 64'(decoded_data), 64'd0);
    chk("reset_ts", 64'(timestamp_last_data), 64'd0);
    repeat (20) @(negedge clk_12MHz);

    send_frame(42'd0);
    drain("all_zeros");
    chk("zeros_dd", 64'(decoded_data), 64'd0);
    chk("zeros_ts", 64'(timestamp_last_data), 64'd0);

    send_frame({1'b0, 17'h1FFFF, 24'hFFFFFF});
    drain("all_ones");
    chk("ones_dd", 64'(decoded_data), 64'h1FFFF);
    chk("ones_ts", 64'(timestamp_last_data), 64'hFFFFFF);

    send_byte(8'hBF, 1'b1, CPB);
    send_byte(8'h7F, 1'b1, CPB);
    send_byte(8'h7F, 1'b1, CPB);
    send_frame(42'd0);
    drain("resync");
    chk("resync_dd", 64'(decoded_data), 64'd0);
    chk("resync_ts", 64'(timestamp_last_data), 64'd0);

    p = {1'b0, 17'h0A5A5, 24'h123456};
    send_byte(frame_byte(p, 0), 1'b1, CPB);
    send_byte(frame_byte(p, 1), 1'b1, CPB);
    send_byte(frame_byte(p, 2), 1'b0, CPB);
    drain("framing_err");
    chk("framing_hold_dd", 64'(decoded_data), 64'd0);
    send_frame(p);
    drain("after_framing");
    chk("after_framing_dd", 64'(decoded_data), 64'h0A5A5);
    chk("after_framing_ts", 64'(timestamp_last_data), 64'h123456);

    rx = 1'b0;
    repeat (20) @(negedge clk_12MHz);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_12MHz);
    drain("glitch");

    send_byte(8'h05, 1'b1, CPB);
    drain("orphan");

    // Reset part-way through a frame and part-way through its 4th byte
    p = {1'b0, 17'h15A3C, 24'hC0FFEE};
    for (int k = 0; k < 3; k++) send_byte(frame_byte(p, k), 1'b1, CPB);
    rx = 1'b0;
    repeat (30) @(negedge clk_12MHz);
    reset_n = 1'b0;
    rx      = 1'b1;
    grp_q.delete();
    m_dd    = '0;
    m_ts    = '0;
    repeat (10) @(negedge clk_12MHz);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_12MHz);
    chk("midreset_dd", 64'(decoded_data), 64'd0);
    chk("midreset_ts", 64'(timestamp_last_data), 64'd0);
    for (int k = 3; k < 6; k++) send_byte(frame_byte(p, k), 1'b1, CPB);
    drain("after_reset_tail");
    chk("tail_dd", 64'(decoded_data), 64'd0);
    chk("tail_ts", 64'(timestamp_last_data), 64'd0);
    send_frame(p);
    drain("after_reset_frame");
    chk("new_frame_dd", 64'(decoded_data), 64'h15A3C);
    chk("new_frame_ts", 64'(timestamp_last_data), 64'hC0FFEE);

    // Random frames: occasional orphan byte, bad top bit, baud jitter and idle gaps
    for (int f = 0; f < 3; f++) begin
      p = {($urandom_range(0, 3) == 0), 17'($urandom), 24'($urandom)};
      if ($urandom_range(0, 2) == 0)
        send_byte(8'($urandom_range(0, 127)), 1'b1, $urandom_range(CPB - 1, CPB + 1));
      for (int k = 0; k < 6; k++) begin
        send_byte(frame_byte(p, k), 1'b1, $urandom_range(CPB - 1, CPB + 1));
        repeat ($urandom_range(0, 40)) @(negedge clk_12MHz);
      end
    end
    drain("random");
    chk("final_dd", 64'(decoded_data), 64'(m_dd));
    chk("final_ts", 64'(timestamp_last_data), 64'(m_ts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

UART receiver and frame reassembler for the tracker's serial link. It deserialises the byte stream produced by the tracker's transmit side and rebuilds each `{decoded_data, timestamp_last_data}` record. It presents each record with a single-cycle valid strobe. It sits on the host-side/bridge FPGA, or in loopback benches, directly behind the `rx` pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200 baud); legal range 8..65535.

Ports:
- `clk_12MHz`  input  1  sole clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, idle high; asynchronous to `clk_12MHz`.
- `data_valid`  output  1  one-cycle pulse: a complete frame was accepted.
- `decoded_data`  output  17  decoded sensor word of the last accepted frame.
- `timestamp_last_data`  output  24  timestamp of the last accepted frame.
- `frame_error`  output  1  one-cycle pulse: byte or frame discarded.

## Operation
- Line format: 8N1, LSB first, 1 start bit (0), 8 data bits, 1 stop bit (1).
- Frame format: 6 bytes carrying 42-bit payload P = {1'b0, decoded_data[16:0], timestamp[23:0]}.
  - Byte 0 = {1, P[41:35]}.
  - Byte k (1..5) = {0, P[41-7k : 35-7k]}.
  - Bit 7 set marks a frame start.
- Input conditioning: `rx` passes through a 2-FF synchroniser; the second stage resets to 1. All decisions use the synchronised value.
- Bit FSM, states IDLE, START, DATA, STOP:
  - IDLE: wait for synchronised `rx` = 0, then go to START with bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample. If 0, go to DATA. If 1 (glitch), return to IDLE silently.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: byte accepted.
    - If 0: framing error. Pulse `frame_error`, drop the byte, reset the frame index to 0, and return to IDLE only after `rx` reads 1.
  - After a good stop sample, return to IDLE immediately; no wait for the stop-bit end.
- Frame assembler, index 0..5, reset 0:
  - Accepted byte with bit7 = 1: load P[41:35], index := 1. This applies at any index, and a partial frame in progress is silently abandoned.
  - Accepted byte with bit7 = 0 and index = 0: discard and pulse `frame_error`.
  - Accepted byte with bit7 = 0 and index 1..5: load its 7-bit slice, index++.
  - When the byte at index 5 is loaded: index := 0.
    - If P[41] = 0: update `decoded_data` and `timestamp_last_data` and pulse `data_valid`.
    - If P[41] = 1: pulse `frame_error`, outputs unchanged.
- Outputs hold their values between frames. Only a valid completed frame changes them.

## Timing
- Reset values: `data_valid` 0, `frame_error` 0, `decoded_data` 0, `timestamp_last_data` 0, FSM IDLE, frame index 0, synchroniser 1.
- `reset_n` asserted mid-byte or mid-frame: the partial byte and partial frame are lost. No pulse is emitted during or after reset.
- Latency: `data_valid` and the updated outputs appear together, on the cycle after the clock edge that samples byte 5's stop bit. Outputs are registered.
- Error latency: `frame_error` rises on the cycle after the offending stop-bit sample.
- Start-edge detection latency is 2 cycles (synchroniser). The mid-bit sampling point therefore lags the true centre by 2 cycles; this is tolerated for CLKS_PER_BIT ≥ 8.
- Back-to-back bytes with zero idle time are supported, since the FSM re-enters IDLE at mid-stop.
- `data_valid` and `frame_error` are never asserted in the same cycle. Each is high for exactly 1 cycle per event.
- Baud tolerance: accepts transmitter rate error up to ±2 % at the default CLKS_PER_BIT.

## Test plan
- All-ones frame: send 0xBF followed by 0x7F ×5, back-to-back, at 104 clk/bit. Require exactly one `data_valid` pulse, with `decoded_data` = 17'h1FFFF and `timestamp_last_data` = 24'hFFFFFF.
- All-zeros frame: send 0x80 followed by 0x00 ×5. Require one `data_valid` pulse, with outputs 0 and no `frame_error`.
- Resync: send 0xBF, 0x7F, 0x7F, then 0x80 followed by 0x00 ×5. Require exactly one `data_valid` pulse, outputs 0, and no `frame_error` for the abandoned partial frame.
- Framing error: send byte 2 of a frame with stop bit = 0. Require one `frame_error` pulse, no `data_valid`, and outputs unchanged. A following good frame must be accepted normally.
- Glitch and orphan handling:
  - Drive a 20-cycle low pulse on `rx`: require no pulses at all.
  - Send lone 0x05: require one `frame_error` pulse.
- Reset mid-frame: assert `reset_n` = 0 after 3 bytes of a valid frame, release it, then send the remaining 3 bytes. Require no `data_valid` and outputs still 0. A full new frame must then be accepted.
